// File: rtl/wb_pkg.sv
// ---------------------------------------------------------------------------
// wb_pkg -- shared Wishbone B3 definitions for the memory-bus arbiter.
//   CTI / BTE encodings used by the masters and the arbiter state encoding.
//   The state values are chosen so that a state value is also the one-hot
//   grant vector (IDLE = 00, OWN0 = 01, OWN1 = 10).
// No ports (package).
// ---------------------------------------------------------------------------
package wb_pkg;

  // Cycle type identifiers
  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_CONST   = 3'b001;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  // Burst type extensions
  localparam logic [1:0] BTE_LINEAR  = 2'b00;
  localparam logic [1:0] BTE_WRAP4   = 2'b01;
  localparam logic [1:0] BTE_WRAP8   = 2'b10;
  localparam logic [1:0] BTE_WRAP16  = 2'b11;

  // Arbiter state; bit N set means master N owns the bus
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } arb_state_e;

endpackage

// File: rtl/wb_arb_mux.sv
// ---------------------------------------------------------------------------
// wb_arb_mux -- combinational master->slave request mux and slave->master
// termination demux for the two-master arbiter.
//   gnt_i     : one-hot owner (00 = nobody)
//   kill_i    : force s_cyc_o/s_stb_o low (watchdog abort)
//   tmo_err_i : per-master watchdog error pulse, ORed into mN_err_o
//   mN_*      : master N request inputs / termination + read data outputs
//   s_*       : slave request outputs / termination + read data inputs
// Handshake: a beat is offered while cyc & stb are high and completes in the
// cycle where the slave returns ack (or rty/err); only the owner ever sees a
// termination, the non-owner's terminations are held at 0.
// ---------------------------------------------------------------------------
module wb_arb_mux
  import wb_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int ADDRESS = 25,
  parameter int SELBITS = 2
) (
  input  logic [1:0]         gnt_i,
  input  logic               kill_i,
  input  logic [1:0]         tmo_err_i,
  input  logic               m0_cyc_i,
  input  logic               m0_stb_i,
  input  logic               m0_we_i,
  input  logic [2:0]         m0_cti_i,
  input  logic [1:0]         m0_bte_i,
  input  logic [ADDRESS-1:0] m0_adr_i,
  input  logic [SELBITS-1:0] m0_sel_i,
  input  logic [WIDTH-1:0]   m0_dat_i,
  output logic               m0_ack_o,
  output logic               m0_rty_o,
  output logic               m0_err_o,
  output logic [WIDTH-1:0]   m0_dat_o,
  input  logic               m1_cyc_i,
  input  logic               m1_stb_i,
  input  logic               m1_we_i,
  input  logic [2:0]         m1_cti_i,
  input  logic [1:0]         m1_bte_i,
  input  logic [ADDRESS-1:0] m1_adr_i,
  input  logic [SELBITS-1:0] m1_sel_i,
  input  logic [WIDTH-1:0]   m1_dat_i,
  output logic               m1_ack_o,
  output logic               m1_rty_o,
  output logic               m1_err_o,
  output logic [WIDTH-1:0]   m1_dat_o,
  output logic               s_cyc_o,
  output logic               s_stb_o,
  output logic               s_we_o,
  output logic [2:0]         s_cti_o,
  output logic [1:0]         s_bte_o,
  output logic [ADDRESS-1:0] s_adr_o,
  output logic [SELBITS-1:0] s_sel_o,
  output logic [WIDTH-1:0]   s_dat_o,
  input  logic               s_ack_i,
  input  logic               s_rty_i,
  input  logic               s_err_i,
  input  logic [WIDTH-1:0]   s_dat_i
);

  logic cyc_int;

  always_comb begin
    // Gated by the owner's live cyc so a dropped cyc leaves the slave in the
    // same cycle, ahead of the state register.
    cyc_int = ((gnt_i[0] & m0_cyc_i) | (gnt_i[1] & m1_cyc_i)) & ~kill_i;
    s_cyc_o = cyc_int;
    s_stb_o = ((gnt_i[0] & m0_stb_i) | (gnt_i[1] & m1_stb_i)) & cyc_int;
    // Non-control fields follow master 0 unless master 1 owns the bus.
    if (gnt_i[1]) begin
      s_we_o  = m1_we_i;
      s_cti_o = m1_cti_i;
      s_bte_o = m1_bte_i;
      s_adr_o = m1_adr_i;
      s_sel_o = m1_sel_i;
      s_dat_o = m1_dat_i;
    end else begin
      s_we_o  = m0_we_i;
      s_cti_o = m0_cti_i;
      s_bte_o = m0_bte_i;
      s_adr_o = m0_adr_i;
      s_sel_o = m0_sel_i;
      s_dat_o = m0_dat_i;
    end
    m0_ack_o = gnt_i[0] & s_ack_i;
    m0_rty_o = gnt_i[0] & s_rty_i;
    m0_err_o = (gnt_i[0] & s_err_i) | tmo_err_i[0];
    m1_ack_o = gnt_i[1] & s_ack_i;
    m1_rty_o = gnt_i[1] & s_rty_i;
    m1_err_o = (gnt_i[1] & s_err_i) | tmo_err_i[1];
    m0_dat_o = s_dat_i;
    m1_dat_o = s_dat_i;
  end

endmodule

// File: rtl/wb_arb2.sv
// ---------------------------------------------------------------------------
// wb_arb2 -- two-master, one-slave Wishbone B3 arbiter.
//   Master 0: CPU data port. Master 1: secondary requester (DMA/video).
//   Registered grant FSM (IDLE/OWN0/OWN1); ownership is held while the owner
//   keeps cyc high, with at least one IDLE cycle between owners.
//   FIXED_PRIO = 0: round-robin on ties; 1: master 0 wins ties.
// Ports: wb_clk_i / wb_rst_ni (async, active low), mN_* master N bus,
//   s_* slave bus, gnt_o one-hot current grant (equals the FSM state).
// Optional: define WB_ARB_TIMEOUT_EN to add an 8-bit watchdog that errors
//   the owner after TIMEOUT unanswered strobe cycles and blocks the slave
//   until the owner drops cyc.
// ---------------------------------------------------------------------------
module wb_arb2
  import wb_pkg::*;
#(
  parameter int         WIDTH      = 16,
  parameter int         ADDRESS    = 25,
  parameter int         SELBITS    = 2,
  parameter int         FIXED_PRIO = 0,
  parameter logic [7:0] TIMEOUT    = 8'd255
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_ni,
  input  logic               m0_cyc_i,
  input  logic               m0_stb_i,
  input  logic               m0_we_i,
  input  logic [2:0]         m0_cti_i,
  input  logic [1:0]         m0_bte_i,
  input  logic [ADDRESS-1:0] m0_adr_i,
  input  logic [SELBITS-1:0] m0_sel_i,
  input  logic [WIDTH-1:0]   m0_dat_i,
  output logic               m0_ack_o,
  output logic               m0_rty_o,
  output logic               m0_err_o,
  output logic [WIDTH-1:0]   m0_dat_o,
  input  logic               m1_cyc_i,
  input  logic               m1_stb_i,
  input  logic               m1_we_i,
  input  logic [2:0]         m1_cti_i,
  input  logic [1:0]         m1_bte_i,
  input  logic [ADDRESS-1:0] m1_adr_i,
  input  logic [SELBITS-1:0] m1_sel_i,
  input  logic [WIDTH-1:0]   m1_dat_i,
  output logic               m1_ack_o,
  output logic               m1_rty_o,
  output logic               m1_err_o,
  output logic [WIDTH-1:0]   m1_dat_o,
  output logic               s_cyc_o,
  output logic               s_stb_o,
  output logic               s_we_o,
  output logic [2:0]         s_cti_o,
  output logic [1:0]         s_bte_o,
  output logic [ADDRESS-1:0] s_adr_o,
  output logic [SELBITS-1:0] s_sel_o,
  output logic [WIDTH-1:0]   s_dat_o,
  input  logic               s_ack_i,
  input  logic               s_rty_i,
  input  logic               s_err_i,
  input  logic [WIDTH-1:0]   s_dat_i,
  output logic [1:0]         gnt_o
);

  arb_state_e state_q, state_d;
  logic       last_q, last_d;   // index of the master served most recently
  logic       kill;
  logic [1:0] tmo_err;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i) begin
          state_d = ((FIXED_PRIO != 0) || last_q) ? OWN0 : OWN1;
        end else if (m0_cyc_i) begin
          state_d = OWN0;
        end else if (m1_cyc_i) begin
          state_d = OWN1;
        end
      end
      OWN0: begin
        if (!m0_cyc_i) begin
          state_d = IDLE;
          last_d  = 1'b0;
        end
      end
      OWN1: begin
        if (!m1_cyc_i) begin
          state_d = IDLE;
          last_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q <= IDLE;
      last_q  <= 1'b1;  // master 0 wins the first tie after reset
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  // State encoding doubles as the one-hot grant.
  assign gnt_o = state_q;

`ifdef WB_ARB_TIMEOUT_EN
  logic [7:0] tmo_q, tmo_d;
  logic       kill_q, kill_d;
  logic       tmo_hit;

  always_comb begin
    tmo_hit = (state_q != IDLE) && !kill_q && (tmo_q == TIMEOUT);
    tmo_d   = tmo_q;
    kill_d  = kill_q;
    if ((state_q == IDLE) || s_ack_i || s_rty_i || s_err_i) begin
      tmo_d = 8'd0;
    end else if (s_stb_o && (tmo_q != 8'hff)) begin
      tmo_d = tmo_q + 8'd1;
    end
    // Abort sticks until the owner lets go of cyc.
    if (state_d == IDLE) begin
      kill_d = 1'b0;
    end else if (tmo_hit) begin
      kill_d = 1'b1;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      tmo_q  <= 8'd0;
      kill_q <= 1'b0;
    end else begin
      tmo_q  <= tmo_d;
      kill_q <= kill_d;
    end
  end

  // The error cycle itself already blocks the slave.
  assign kill    = kill_q | tmo_hit;
  assign tmo_err = {gnt_o[1] & tmo_hit, gnt_o[0] & tmo_hit};
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign kill           = 1'b0;
  assign tmo_err        = 2'b00;
`endif

  wb_arb_mux #(
    .WIDTH   (WIDTH),
    .ADDRESS (ADDRESS),
    .SELBITS (SELBITS)
  ) u_mux (
    .gnt_i     (gnt_o),
    .kill_i    (kill),
    .tmo_err_i (tmo_err),
    .m0_cyc_i  (m0_cyc_i),
    .m0_stb_i  (m0_stb_i),
    .m0_we_i   (m0_we_i),
    .m0_cti_i  (m0_cti_i),
    .m0_bte_i  (m0_bte_i),
    .m0_adr_i  (m0_adr_i),
    .m0_sel_i  (m0_sel_i),
    .m0_dat_i  (m0_dat_i),
    .m0_ack_o  (m0_ack_o),
    .m0_rty_o  (m0_rty_o),
    .m0_err_o  (m0_err_o),
    .m0_dat_o  (m0_dat_o),
    .m1_cyc_i  (m1_cyc_i),
    .m1_stb_i  (m1_stb_i),
    .m1_we_i   (m1_we_i),
    .m1_cti_i  (m1_cti_i),
    .m1_bte_i  (m1_bte_i),
    .m1_adr_i  (m1_adr_i),
    .m1_sel_i  (m1_sel_i),
    .m1_dat_i  (m1_dat_i),
    .m1_ack_o  (m1_ack_o),
    .m1_rty_o  (m1_rty_o),
    .m1_err_o  (m1_err_o),
    .m1_dat_o  (m1_dat_o),
    .s_cyc_o   (s_cyc_o),
    .s_stb_o   (s_stb_o),
    .s_we_o    (s_we_o),
    .s_cti_o   (s_cti_o),
    .s_bte_o   (s_bte_o),
    .s_adr_o   (s_adr_o),
    .s_sel_o   (s_sel_o),
    .s_dat_o   (s_dat_o),
    .s_ack_i   (s_ack_i),
    .s_rty_i   (s_rty_i),
    .s_err_i   (s_err_i),
    .s_dat_i   (s_dat_i)
  );

endmodule
